binary_maxpool_stage: RTL and testbench

Downstream stage of the binary 3x3 convolution engine: reads the ±1 feature matrices that the convolution stage has written to output SRAM and produces 2x2, stride-2 max-pooled matrices in a second SRAM region. It handles any number of matrices back to back, stops at the end-of-data marker, and uses the same run/busy start handshake and 12-bit-address / 16-bit-data SRAM ports as the convolution engine.

---
 rtl/binary_maxpool_stage_pkg.sv | 26 ++
 rtl/pool_row_combine.sv | 23 ++
 rtl/binary_maxpool_stage.sv | 143 ++++++++++++++
 tb/tb_binary_maxpool_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/binary_maxpool_stage_pkg.sv
// Shared definitions for the binary max-pool stage: SRAM widths, end marker, FSM encoding.
// SRAM widths match the convolution engine so both stages share one memory map.
package binary_maxpool_stage_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] END_WORD_DEFAULT = 16'h00FF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_NROWS,
    S_RD_NCOLS,
    S_WR_HDR,
    S_RD_A,
    S_RD_B,
    S_WR_ROW,
    S_SKIP,
    S_WR_END
  } state_t;

  // States that consume one word of read data in the cycle they are active.
  function automatic logic is_read_state(input state_t s);
    return s inside {S_RD_NROWS, S_RD_NCOLS, S_RD_A, S_RD_B, S_SKIP};
  endfunction

endpackage

// File: rtl/pool_row_combine.sv
// Pools two adjacent +/-1 rows into one word: bit j = OR of the 2x2 window at columns 2j, 2j+1.
// Purely combinational; columns at or above pcols are forced to 0.
module pool_row_combine
  import binary_maxpool_stage_pkg::*;
#(
  parameter int MAX_COLS = 16
) (
  input  logic [DATA_W-1:0] row_a,
  input  logic [DATA_W-1:0] row_b,
  input  logic [DATA_W-1:0] pcols,
  output logic [DATA_W-1:0] pooled
);

  always_comb begin
    pooled = '0;
    for (int j = 0; j < MAX_COLS / 2; j++) begin
      if (DATA_W'(j) < pcols) begin
        pooled[j] = row_a[2*j] | row_a[2*j+1] | row_b[2*j] | row_b[2*j+1];
      end
    end
  end

endmodule

// File: rtl/binary_maxpool_stage.sv
// 2x2 stride-2 max-pool over +/-1 matrices streamed from SRAM; one pooled word per 3 cycles.
// Started by dut_run in IDLE; busy until the end-marker write. No backpressure: SRAM is fixed 1-cycle.
module binary_maxpool_stage
  import binary_maxpool_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RD_BASE  = 12'h000,
  parameter logic [ADDR_W-1:0] WR_BASE  = 12'h000,
  parameter logic [DATA_W-1:0] END_WORD = END_WORD_DEFAULT,
  parameter int                MAX_COLS = 16
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] pool_sram_read_address,
  input  logic [DATA_W-1:0] sram_pool_read_data,
  output logic [ADDR_W-1:0] pool_sram_write_address,
  output logic [DATA_W-1:0] pool_sram_write_data,
  output logic              pool_sram_write_enable
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic              hdr_sel;
  logic              odd_q;
  logic [DATA_W-2:0] pairs_left;
  logic [DATA_W-2:0] pcols_q;
  logic [DATA_W-1:0] skip_left;
  logic [DATA_W-1:0] row_a, row_b;
  logic [DATA_W-1:0] pooled;
  logic              no_pairs;

  assign no_pairs = (pairs_left == '0) || (pcols_q == '0);

  assign pool_sram_read_address  = rd_ptr;
  assign pool_sram_write_address = wr_ptr;

  pool_row_combine #(
    .MAX_COLS(MAX_COLS)
  ) u_combine (
    .row_a (row_a),
    .row_b (row_b),
    .pcols ({1'b0, pcols_q}),
    .pooled(pooled)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (dut_run) state_nxt = S_RD_NROWS;
      S_RD_NROWS: state_nxt = (sram_pool_read_data == END_WORD) ? S_WR_END : S_RD_NCOLS;
      S_RD_NCOLS: state_nxt = S_WR_HDR;
      S_WR_HDR: begin
        if (hdr_sel) begin
          if (!no_pairs)              state_nxt = S_RD_A;
          else if (skip_left != '0)   state_nxt = S_SKIP;
          else                        state_nxt = S_RD_NROWS;
        end
      end
      S_RD_A:     state_nxt = S_RD_B;
      S_RD_B:     state_nxt = S_WR_ROW;
      S_WR_ROW: begin
        if (pairs_left == (DATA_W-1)'(1)) state_nxt = odd_q ? S_SKIP : S_RD_NROWS;
        else                              state_nxt = S_RD_A;
      end
      S_SKIP:     if (skip_left == DATA_W'(1)) state_nxt = S_RD_NROWS;
      S_WR_END:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pool_sram_write_enable = 1'b0;
    pool_sram_write_data   = '0;
    unique case (state)
      S_WR_HDR: begin
        pool_sram_write_enable = 1'b1;
        pool_sram_write_data   = hdr_sel ? {1'b0, pcols_q} : {1'b0, pairs_left};
      end
      S_WR_ROW: begin
        pool_sram_write_enable = 1'b1;
        pool_sram_write_data   = pooled;
      end
      S_WR_END: begin
        pool_sram_write_enable = 1'b1;
        pool_sram_write_data   = END_WORD;
      end
      default: ;
    endcase
  end

  // The read pointer always presents the word the next read state will consume,
  // so it advances on entry to every read state.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_ptr     <= RD_BASE;
      wr_ptr     <= WR_BASE;
      dut_busy   <= 1'b0;
      hdr_sel    <= 1'b0;
      odd_q      <= 1'b0;
      pairs_left <= '0;
      pcols_q    <= '0;
      skip_left  <= '0;
      row_a      <= '0;
      row_b      <= '0;
    end else begin
      if (is_read_state(state_nxt)) rd_ptr <= rd_ptr + ADDR_W'(1);
      else if (state == S_WR_END)   rd_ptr <= RD_BASE;

      if (state == S_WR_END)           wr_ptr <= WR_BASE;
      else if (pool_sram_write_enable) wr_ptr <= wr_ptr + ADDR_W'(1);

      dut_busy <= (state_nxt != S_IDLE);
      hdr_sel  <= (state == S_WR_HDR) && !hdr_sel;

      case (state)
        S_RD_NROWS: begin
          pairs_left <= sram_pool_read_data[DATA_W-1:1];
          odd_q      <= sram_pool_read_data[0];
          skip_left  <= sram_pool_read_data;
        end
        S_RD_NCOLS: pcols_q <= sram_pool_read_data[DATA_W-1:1];
        S_RD_A:     row_a   <= sram_pool_read_data;
        S_RD_B:     row_b   <= sram_pool_read_data;
        S_WR_ROW: begin
          pairs_left <= pairs_left - (DATA_W-1)'(1);
          skip_left  <= DATA_W'(1);
        end
        S_SKIP:     skip_left <= skip_left - DATA_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_maxpool_stage.sv
// Randomized and directed streams through the max-pool stage, scored against a queue-based reference.
module tb_binary_maxpool_stage;

  localparam logic [11:0] RDB  = 12'h010;
  localparam logic [11:0] WRB  = 12'h800;
  localparam logic [15:0] ENDW = 16'h00FF;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        dut_run = 1'b0;
  logic        dut_busy;
  logic [11:0] ra, wa;
  logic [15:0] rd, wd;
  logic        we;

  logic [15:0] mem [0:4095];
  logic [27:0] exp_q [$];
  logic [15:0] stim [$];
  logic [27:0] e;
  int          checks = 0;
  int          errors = 0;
  int          budget;

  always #5 clk = ~clk;

  binary_maxpool_stage #(
    .RD_BASE (RDB),
    .WR_BASE (WRB),
    .END_WORD(ENDW),
    .MAX_COLS(16)
  ) dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .pool_sram_read_address (ra),
    .sram_pool_read_data    (rd),
    .pool_sram_write_address(wa),
    .pool_sram_write_data   (wd),
    .pool_sram_write_enable (we)
  );

  always @(posedge clk) rd <= mem[ra];

  // Scoreboard monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (we) begin
      checks++;
      if (!reset_b || !dut_busy) begin
        errors++;
        $display("FAIL write_strobe_state: addr %h data %h reset_b=%b busy=%b, required no strobe", wa, wd, reset_b, dut_busy);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, required none", wa, wd);
      end else begin
        e = exp_q.pop_front();
        if ({wa, wd} !== e) begin
          errors++;
          $display("FAIL write_word: got addr %h data %h, required addr %h data %h", wa, wd, e[27:16], e[15:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_busy"}, dut_busy, 0);
    check({name, "_we"}, we, 0);
    check({name, "_wdata"}, wd, 0);
    check({name, "_raddr"}, ra, RDB);
    check({name, "_waddr"}, wa, WRB);
  endtask

  // Reference: walk the stream word list and derive every pooled output word.
  task automatic build_expected();
    int p, k, pr, pc;
    logic [15:0] n, c, a, b, o;
    p = 0;
    k = 0;
    budget = 6;
    exp_q.delete();
    while (p < stim.size()) begin
      n = stim[p];
      if (n == ENDW) begin
        exp_q.push_back({WRB + 12'(k), ENDW});
        break;
      end
      c  = stim[p+1];
      pr = int'(n) / 2;
      pc = int'(c) / 2;
      exp_q.push_back({WRB + 12'(k), 16'(pr)}); k++;
      exp_q.push_back({WRB + 12'(k), 16'(pc)}); k++;
      if (pr > 0 && pc > 0) begin
        for (int i = 0; i < pr; i++) begin
          a = stim[p + 2 + 2*i];
          b = stim[p + 3 + 2*i];
          o = 16'h0000;
          for (int j = 0; j < pc && j < 8; j++) o[j] = a[2*j] | a[2*j+1] | b[2*j] | b[2*j+1];
          exp_q.push_back({WRB + 12'(k), o}); k++;
        end
      end
      budget += 2 * int'(n) + 8;
      p += 2 + int'(n);
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < stim.size(); i++) mem[RDB + 12'(i)] = stim[i];
    mem[RDB + 12'(stim.size())] = 16'($urandom);
  endtask

  task automatic add_matrix(input int nr, input int nc, input bit rnd, input logic [15:0] fill);
    stim.push_back(16'(nr));
    stim.push_back(16'(nc));
    for (int i = 0; i < nr; i++) stim.push_back(rnd ? 16'($urandom) : fill);
  endtask

  task automatic run_stream(input string name, input bit poke);
    int cyc;
    load_mem();
    build_expected();
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    check({name, "_busy_rise"}, dut_busy, 1);
    cyc = 1;
    while (dut_busy && cyc < 2000) begin
      dut_run = (poke && cyc == 4);
      @(negedge clk);
      cyc++;
    end
    dut_run = 1'b0;
    check({name, "_busy_fall"}, dut_busy, 0);
    check({name, "_cycle_budget"}, (cyc - 1) <= budget, 1);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int init_sz, n;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    stim.delete();
    stim = '{16'd4, 16'd4, 16'h0001, 16'h0000, 16'h0000, 16'h0008, ENDW};
    run_stream("m4x4", 0);

    stim.delete();
    add_matrix(5, 5, 0, 16'h001F);
    stim.push_back(ENDW);
    run_stream("m5x5", 0);

    stim.delete();
    add_matrix(16, 16, 0, 16'hFFFF);
    add_matrix(2, 2, 0, 16'h0000);
    stim.push_back(ENDW);
    run_stream("back_to_back", 0);

    stim.delete();
    stim.push_back(ENDW);
    run_stream("empty", 0);

    stim.delete();
    add_matrix(1, 8, 1, 16'h0000);
    add_matrix(4, 1, 1, 16'h0000);
    add_matrix(3, 6, 1, 16'h0000);
    stim.push_back(ENDW);
    run_stream("degenerate", 0);

    for (int t = 0; t < 8; t++) begin
      stim.delete();
      for (int m = 0; m < $urandom_range(1, 3); m++)
        add_matrix($urandom_range(0, 9), $urandom_range(0, 16), 1, 16'h0000);
      stim.push_back(ENDW);
      run_stream("random", t[0]);
    end

    // Abort a run mid-way through its row writes, then rerun the same stream.
    stim.delete();
    add_matrix(16, 16, 1, 16'h0000);
    stim.push_back(ENDW);
    load_mem();
    build_expected();
    init_sz = exp_q.size();
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    n = 0;
    while (exp_q.size() > init_sz - 6 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_rows", exp_q.size() <= init_sz - 6, 1);
    @(posedge clk);
    #1 reset_b = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_reset_values("abort");
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    run_stream("rerun", 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
